// File: rtl/block_code_a20_pkg.sv
// Shared constants, the (20,A) basis table and the encoder state encoding.
// Used by both block_encode_a20 and block_decode_a20.
package block_code_a20_pkg;

    localparam int unsigned NUM_SYMBOLS = 20;
    localparam int unsigned MAX_A       = 13;
    localparam int unsigned A_W         = 4;
    localparam int unsigned IDX_W       = 5;

    // M_TABLE[i][n] = M(i,n); each literal reads n=12 on the left down to n=0 on the right
    localparam logic [MAX_A-1:0] M_TABLE [NUM_SYMBOLS] = '{
        13'b0110000000011,
        13'b0111000000111,
        13'b1111101001001,
        13'b1110100001101,
        13'b1110010001111,
        13'b1110111010011,
        13'b1111101010101,
        13'b1110110011001,
        13'b1111010011011,
        13'b1111001011101,
        13'b1111011100101,
        13'b1110101100111,
        13'b1111110101001,
        13'b1111010101011,
        13'b1010010110001,
        13'b1011011110011,
        13'b1101001110111,
        13'b1100100111001,
        13'b0000011111011,
        13'b0000001100001
    };

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ENCODE,
        EMIT
    } state_t;

endpackage

// File: rtl/block_encode_a20_core.sv
// Combinational (20,A) codeword: b_i is the parity of the information bits
// selected by row i of the basis table.
module block_encode_a20_core
    import block_code_a20_pkg::*;
(
    input  logic [MAX_A-1:0]       a,
    output logic [NUM_SYMBOLS-1:0] b_c
);

    always_comb begin
        b_c = '0;
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            b_c[i] = ^(a & M_TABLE[i]);
        end
    end

endmodule

// File: rtl/block_encode_a20.sv
// Streaming (20,A) block encoder: collects A serial information bits, encodes
// them in one cycle, then emits 20 BPSK soft symbols over AXI4-Stream.
module block_encode_a20 #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int          AMPLITUDE   = 64,
    parameter int unsigned NUM_SYMBOLS = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   code_length,
    input  logic                         code_length_valid,
    input  logic                         s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         err_tlast
);
    import block_code_a20_pkg::*;

    localparam logic [DATA_WIDTH-1:0] SYM_POS  = DATA_WIDTH'(AMPLITUDE);
    localparam logic [DATA_WIDTH-1:0] SYM_NEG  = DATA_WIDTH'(-AMPLITUDE);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_SYMBOLS - 1);

    state_t                 state, state_nxt;
    logic [A_W-1:0]         a_len, a_len_nxt;
    logic [A_W-1:0]         k, k_nxt;
    logic [A_W-1:0]         pend_len, pend_len_nxt;
    logic                   pend_valid, pend_valid_nxt;
    logic                   err_nxt;
    logic [MAX_A-1:0]       a_reg, a_nxt;
    logic [NUM_SYMBOLS-1:0] b_reg, b_nxt, enc_b_c;
    logic [IDX_W-1:0]       sym_idx, idx_nxt;
    logic                   s_ready_nxt, m_valid_nxt, m_last_nxt;
    logic [DATA_WIDTH-1:0]  m_data_nxt;
    logic                   s_hs, m_hs, cfg_ok, last_pos;

    function automatic logic [DATA_WIDTH-1:0] sym_of(input logic bit_v);
        return bit_v ? SYM_NEG : SYM_POS;
    endfunction

    block_encode_a20_core u_core (
        .a   (a_reg),
        .b_c (enc_b_c)
    );

    assign s_hs     = s_axis_tvalid && s_axis_tready;
    assign m_hs     = m_axis_tvalid && m_axis_tready;
    assign cfg_ok   = code_length_valid && (code_length != '0) && (code_length <= A_W'(MAX_A));
    assign last_pos = (k == a_len - A_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        a_len_nxt      = a_len;
        k_nxt          = k;
        pend_len_nxt   = pend_len;
        pend_valid_nxt = pend_valid;
        err_nxt        = err_tlast;
        a_nxt          = a_reg;
        b_nxt          = b_reg;
        idx_nxt        = sym_idx;
        s_ready_nxt    = 1'b0;
        m_valid_nxt    = m_axis_tvalid;
        m_last_nxt     = m_axis_tlast;
        m_data_nxt     = m_axis_tdata;

        unique case (state)
            IDLE: begin
                if (cfg_ok) begin
                    a_len_nxt   = code_length;
                    k_nxt       = '0;
                    a_nxt       = '0;
                    s_ready_nxt = 1'b1;
                    state_nxt   = COLLECT;
                end
            end
            COLLECT: begin
                s_ready_nxt = 1'b1;
                // Before the first bit a new length takes effect at once; later it waits
                if (cfg_ok) begin
                    if ((k == '0) && !s_hs) begin
                        a_len_nxt = code_length;
                    end else begin
                        pend_valid_nxt = 1'b1;
                        pend_len_nxt   = code_length;
                    end
                end
                if (s_hs) begin
                    a_nxt[k] = s_axis_tdata;
                    k_nxt    = k + A_W'(1);
                    if (last_pos || s_axis_tlast) begin
                        if (last_pos != s_axis_tlast) err_nxt = 1'b1;
                        s_ready_nxt = 1'b0;
                        state_nxt   = ENCODE;
                    end
                end
            end
            ENCODE: begin
                if (cfg_ok) begin
                    pend_valid_nxt = 1'b1;
                    pend_len_nxt   = code_length;
                end
                b_nxt       = enc_b_c;
                idx_nxt     = '0;
                m_valid_nxt = 1'b1;
                m_last_nxt  = 1'b0;
                m_data_nxt  = sym_of(enc_b_c[0]);
                state_nxt   = EMIT;
            end
            EMIT: begin
                if (cfg_ok) begin
                    pend_valid_nxt = 1'b1;
                    pend_len_nxt   = code_length;
                end
                if (m_hs) begin
                    if (sym_idx == LAST_IDX) begin
                        m_valid_nxt = 1'b0;
                        m_last_nxt  = 1'b0;
                        m_data_nxt  = '0;
                        s_ready_nxt = 1'b1;
                        k_nxt       = '0;
                        a_nxt       = '0;
                        state_nxt   = COLLECT;
                        if (pend_valid_nxt) begin
                            a_len_nxt      = pend_len_nxt;
                            pend_valid_nxt = 1'b0;
                        end
                    end else begin
                        idx_nxt    = sym_idx + IDX_W'(1);
                        m_data_nxt = sym_of(b_reg[idx_nxt]);
                        m_last_nxt = (idx_nxt == LAST_IDX);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_len         <= '0;
            k             <= '0;
            pend_len      <= '0;
            pend_valid    <= 1'b0;
            err_tlast     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sym_idx       <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            a_len         <= a_len_nxt;
            k             <= k_nxt;
            pend_len      <= pend_len_nxt;
            pend_valid    <= pend_valid_nxt;
            err_tlast     <= err_nxt;
            a_reg         <= a_nxt;
            b_reg         <= b_nxt;
            sym_idx       <= idx_nxt;
            s_axis_tready <= s_ready_nxt;
            m_axis_tvalid <= m_valid_nxt;
            m_axis_tlast  <= m_last_nxt;
            m_axis_tdata  <= m_data_nxt;
        end
    end

endmodule

// File: tb/tb_block_encode_a20.sv
// Self-checking bench for block_encode_a20: table vectors, hand sequences for
// latency / reconfiguration / reset abort, and randomized codewords.
module tb_block_encode_a20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code_length = '0;
    logic       code_length_valid = 1'b0;
    logic       s_axis_tdata = 1'b0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       err_tlast;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    int rdy_cnt = 0;
    int emit_ready_viol = 0;
    logic [7:0] beat_q [$];
    logic       last_q [$];
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = '0;
    logic       last_prev = 1'b0;
    logic       err_exp = 1'b0;

    // Basis rows written as M(i,0) M(i,1) ... M(i,12), left to right
    logic [12:0] tb_m [20];

    typedef struct {
        int          len;
        logic [12:0] bits;
        int          tlast_at;
        logic        exp_err;
        logic [7:0]  exp_fill;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    block_encode_a20 dut (
        .clk               (clk),
        .rst               (rst),
        .code_length       (code_length),
        .code_length_valid (code_length_valid),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .err_tlast         (err_tlast)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: codeword from the basis table with counted parity, zero-filled past A or tlast
    function automatic logic [159:0] model_word(input int len, input logic [12:0] bits, input int tlast_at);
        logic [159:0] w;
        w = '0;
        for (int i = 0; i < 20; i++) begin
            int ones;
            ones = 0;
            for (int n = 0; n < 13; n++) begin
                if (n < len && n <= tlast_at && bits[n] && tb_m[i][12-n]) ones++;
            end
            w[i*8 +: 8] = (ones % 2 == 1) ? 8'hC0 : 8'h40;
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", 160'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                      160'({1'b1, last_prev, data_prev}));
            if (m_axis_tvalid && s_axis_tready) emit_ready_viol++;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_q.push_back(m_axis_tdata);
                last_q.push_back(m_axis_tlast);
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            data_prev  = m_axis_tdata;
            last_prev  = m_axis_tlast;
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (rdy_cnt % 30) >= 20;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            rdy_cnt++;
        end
    end

    task automatic strobe(input int v);
        code_length       = 4'(v);
        code_length_valid = 1'b1;
        @(posedge clk);
        #1;
        code_length_valid = 1'b0;
    endtask

    task automatic send_bits(input int n_send, input logic [12:0] bits, input int tlast_at);
        for (int n = 0; n < n_send; n++) begin
            int t;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = bits[n];
            s_axis_tlast  = (n == tlast_at);
            t = 0;
            @(negedge clk);
            while (!s_axis_tready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!s_axis_tready) begin
                check("s_ready_timeout", 160'(s_axis_tready), 160'(1));
                break;
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 1'b0;
    endtask

    task automatic expect_word(input logic [159:0] exp, input string tag);
        logic [159:0] obs;
        logic [19:0]  lasts;
        int t;
        obs = '0;
        lasts = '0;
        t = 0;
        while (beat_q.size() < 20 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        check({tag, "_beats"}, 160'(beat_q.size()), 160'(20));
        for (int i = 0; i < 20; i++) begin
            if (beat_q.size() == 0) break;
            obs[i*8 +: 8] = beat_q.pop_front();
            lasts[i]      = last_q.pop_front();
        end
        check({tag, "_data"}, obs, exp);
        check({tag, "_tlast"}, 160'(lasts), 160'(20'h80000));
        beat_q.delete();
        last_q.delete();
        #1;
    endtask

    task automatic run_word(input int len, input logic [12:0] bits, input int tlast_at,
                            input logic [159:0] exp, input string tag);
        int n_send;
        n_send = (tlast_at < len) ? tlast_at + 1 : len;
        strobe(len);
        send_bits(n_send, bits, tlast_at);
        expect_word(exp, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        beat_q.delete();
        last_q.delete();
        err_exp = 1'b0;
    endtask

    initial begin
        logic [12:0]  bits;
        logic [159:0] exp;
        int           len;

        tb_m = '{13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
                 13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
                 13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
                 13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
                 13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000};

        vecs[0] = '{len: 1,  bits: 13'h0001, tlast_at: 0,  exp_err: 1'b0, exp_fill: 8'hC0};
        vecs[1] = '{len: 13, bits: 13'h0000, tlast_at: 12, exp_err: 1'b0, exp_fill: 8'h40};
        vecs[2] = '{len: 13, bits: 13'h0001, tlast_at: 12, exp_err: 1'b0, exp_fill: 8'hC0};
        vecs[3] = '{len: 13, bits: 13'h1A5B, tlast_at: 12, exp_err: 1'b0, exp_fill: 8'h00};
        vecs[4] = '{len: 7,  bits: 13'h0055, tlast_at: 6,  exp_err: 1'b0, exp_fill: 8'h00};
        vecs[5] = '{len: 5,  bits: 13'h001F, tlast_at: 2,  exp_err: 1'b1, exp_fill: 8'h00};
        vecs[6] = '{len: 3,  bits: 13'h0005, tlast_at: 15, exp_err: 1'b1, exp_fill: 8'h00};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 160'(s_axis_tready), 160'(0));
        check("rst_m_valid", 160'(m_axis_tvalid), 160'(0));
        check("rst_m_last",  160'(m_axis_tlast),  160'(0));
        check("rst_m_data",  160'(m_axis_tdata),  160'(0));
        check("rst_err",     160'(err_tlast),     160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Illegal lengths leave the block idle
        strobe(14);
        repeat (3) @(posedge clk);
        #1;
        check("illegal14_ready", 160'(s_axis_tready), 160'(0));
        strobe(0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal0_ready", 160'(s_axis_tready), 160'(0));

        // Latency: tvalid low during the ENCODE cycle, high the cycle after
        strobe(4);
        send_bits(4, 13'h000B, 3);
        @(negedge clk);
        check("lat_encode_valid", 160'(m_axis_tvalid), 160'(0));
        @(negedge clk);
        check("lat_emit_valid", 160'(m_axis_tvalid), 160'(1));
        expect_word(model_word(4, 13'h000B, 3), "lat_word");

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            exp = (vecs[v].exp_fill != 8'h00) ? {20{vecs[v].exp_fill}}
                                              : model_word(vecs[v].len, vecs[v].bits, vecs[v].tlast_at);
            run_word(vecs[v].len, vecs[v].bits, vecs[v].tlast_at, exp, $sformatf("vec%0d", v));
            err_exp = err_exp | vecs[v].exp_err;
            check($sformatf("vec%0d_err", v), 160'(err_tlast), 160'(err_exp));
        end

        // Pending reconfiguration during EMIT
        do_reset();
        strobe(8);
        send_bits(8, 13'h00B6, 7);
        begin
            int t;
            t = 0;
            while (beat_q.size() < 3 && t < 200) begin
                @(posedge clk);
                t++;
            end
            #1;
        end
        strobe(4);
        expect_word(model_word(8, 13'h00B6, 7), "pend_a8");
        send_bits(4, 13'h0009, 3);
        @(negedge clk);
        check("pend_a4_ready_after4", 160'(s_axis_tready), 160'(0));
        expect_word(model_word(4, 13'h0009, 3), "pend_a4");
        check("pend_err", 160'(err_tlast), 160'(0));

        // Stalled output for every length, then random ready and random lengths
        do_reset();
        rdy_mode = 1;
        for (int a = 1; a <= 13; a++) begin
            bits = 13'($urandom);
            run_word(a, bits, a - 1, model_word(a, bits, a - 1), $sformatf("stall_a%0d", a));
        end
        rdy_mode = 2;
        for (int r = 0; r < 12; r++) begin
            len  = int'($urandom_range(1, 13));
            bits = 13'($urandom);
            run_word(len, bits, len - 1, model_word(len, bits, len - 1), $sformatf("rand%0d", r));
        end
        rdy_mode = 0;
        check("rand_err", 160'(err_tlast), 160'(0));
        check("emit_ready_low", 160'(emit_ready_viol), 160'(0));

        // Reset while beat 7 is on the bus aborts the codeword
        strobe(6);
        send_bits(6, 13'h002D, 5);
        begin
            int t;
            t = 0;
            while (beat_q.size() < 7 && t < 200) begin
                @(posedge clk);
                t++;
            end
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 160'(m_axis_tvalid), 160'(0));
        check("abort_idle_ready", 160'(s_axis_tready), 160'(0));
        beat_q.delete();
        last_q.delete();
        @(posedge clk);
        #1;
        run_word(3, 13'h0006, 2, model_word(3, 13'h0006, 2), "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
